pipe_stage_fifo: RTL and testbench

Parametrised successor to the single-register decode pipeline stage: a valid/rdy elastic pipeline stage holding up to DEPTH entries of DATA_W bits, with CPU halt, pipeline flush, per-entry sequence tag and occupancy output. It sits between any two RisKy1 pipeline stages (Fetch→Decode, Decode→Execute, …). The producing stage's combinational core drives `in_data`; the consuming stage reads `out_data`. DEPTH=1 reproduces the legacy one-entry behaviour.

---
 rtl/pipe_stage_fifo_pkg.sv | 17 +
 rtl/pipe_stage_fifo_if.sv | 25 ++
 rtl/pipe_stage_fifo_ctrl.sv | 72 +++++++
 rtl/pipe_stage_fifo.sv | 67 ++++++
 tb/tb_pipe_stage_fifo.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_fifo_pkg.sv
// Shared types and helpers for the elastic pipeline stage FIFO.
package pipe_stage_fifo_pkg;

   // Occupancy update selected from the push/pop handshakes of a cycle.
   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_INC,
      CNT_DEC
   } cnt_op_e;

   // Circular pointer advance; wraps at depth without assuming a power of two.
   function automatic int unsigned psf_wrap_inc(input int unsigned ptr,
                                                input int unsigned depth);
      return (ptr + 1 >= depth) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/pipe_stage_fifo_if.sv
// Valid/rdy handshake bundle between two pipeline stages.
interface pipe_stage_fifo_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 4
);
   logic              in_valid;
   logic              in_rdy;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_rdy;
   logic [DATA_W-1:0] out_data;
   logic [TAG_W-1:0]  out_tag;

   // Environment side: producer feeding the stage and consumer draining it.
   modport master (
      output in_valid, in_data, out_rdy,
      input  in_rdy, out_valid, out_data, out_tag
   );

   // Stage side.
   modport slave (
      input  in_valid, in_data, out_rdy,
      output in_rdy, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/pipe_stage_fifo_ctrl.sv
// Pointer, occupancy and tag bookkeeping for pipe_stage_fifo; storage lives in the parent.
module psf_ctrl
   import pipe_stage_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned PTR_W = 1,
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             cpu_halt,
   input  logic             pipe_flush,
   input  logic             in_valid,
   input  logic             out_rdy,
   output logic             in_rdy,
   output logic             out_valid,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [TAG_W-1:0] tag_cnt,
   output logic [CNT_W-1:0] count
);
   logic    rd_en;
   cnt_op_e cnt_op;

   // Handshake qualification; a pop frees a slot so a full stage still accepts.
   always_comb begin
      out_valid = (count != '0);
      in_rdy    = !reset_in && !cpu_halt && !pipe_flush &&
                  ((count < CNT_W'(DEPTH)) || out_rdy);
      wr_en     = in_valid && in_rdy;
      rd_en     = out_valid && out_rdy;
   end

   // Occupancy change for this cycle; simultaneous push and pop cancel.
   always_comb begin
      cnt_op = CNT_HOLD;
      unique case ({wr_en, rd_en})
         2'b10:   cnt_op = CNT_INC;
         2'b01:   cnt_op = CNT_DEC;
         default: cnt_op = CNT_HOLD;
      endcase
   end

   // State update; flush empties the buffer but keeps tag_cnt so tags stay unique.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         tag_cnt <= '0;
      end else if (pipe_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr  <= PTR_W'(psf_wrap_inc(32'(wr_ptr), DEPTH));
            tag_cnt <= tag_cnt + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= PTR_W'(psf_wrap_inc(32'(rd_ptr), DEPTH));
         end
         case (cnt_op)
            CNT_INC: count <= count + 1'b1;
            CNT_DEC: count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic valid/rdy pipeline stage holding up to DEPTH tagged entries.
module pipe_stage_fifo
   import pipe_stage_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned TAG_W  = 4
) (
   input  logic                         clk_in,
   input  logic                         reset_in,
   input  logic                         cpu_halt,
   input  logic                         pipe_flush,
   pipe_stage_fifo_if.slave             bus,
   output logic [$clog2(DEPTH+1)-1:0]   count_out
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } psf_entry_t;

   psf_entry_t       mem [DEPTH];
   psf_entry_t       head;
   logic             wr_en;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [TAG_W-1:0] tag_cnt;
   logic [CNT_W-1:0] count;

   psf_ctrl #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .cpu_halt   (cpu_halt),
      .pipe_flush (pipe_flush),
      .in_valid   (bus.in_valid),
      .out_rdy    (bus.out_rdy),
      .in_rdy     (bus.in_rdy),
      .out_valid  (bus.out_valid),
      .wr_en      (wr_en),
      .wr_ptr     (wr_ptr),
      .rd_ptr     (rd_ptr),
      .tag_cnt    (tag_cnt),
      .count      (count)
   );

   // Entry storage; contents need no reset since out_* are masked when empty.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         mem[wr_ptr] <= '{data: bus.in_data, tag: tag_cnt};
      end
   end

   // Head presentation from registered state only; zeros when empty.
   always_comb begin
      head          = mem[rd_ptr];
      bus.out_data  = bus.out_valid ? head.data : '0;
      bus.out_tag   = bus.out_valid ? head.tag  : '0;
      count_out     = count;
   end
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Self-checking bench: four stage configurations driven in lockstep against a queue model.
module tb_pipe_stage_fifo;
   localparam int N = 4;

   logic       clk_in = 1'b0;
   logic       reset_in, cpu_halt, pipe_flush, in_valid, out_rdy;
   logic [7:0] in_data;

   always #5 clk_in = ~clk_in;

   pipe_stage_fifo_if #(.DATA_W(8), .TAG_W(4)) b0 ();
   pipe_stage_fifo_if #(.DATA_W(8), .TAG_W(4)) b1 ();
   pipe_stage_fifo_if #(.DATA_W(8), .TAG_W(4)) b2 ();
   pipe_stage_fifo_if #(.DATA_W(8), .TAG_W(2)) b3 ();

   logic [1:0] cnt0;
   logic [1:0] cnt1;
   logic [2:0] cnt2;
   logic [0:0] cnt3;

   assign b0.in_valid = in_valid; assign b0.in_data = in_data; assign b0.out_rdy = out_rdy;
   assign b1.in_valid = in_valid; assign b1.in_data = in_data; assign b1.out_rdy = out_rdy;
   assign b2.in_valid = in_valid; assign b2.in_data = in_data; assign b2.out_rdy = out_rdy;
   assign b3.in_valid = in_valid; assign b3.in_data = in_data; assign b3.out_rdy = out_rdy;

   pipe_stage_fifo #(.DATA_W(8), .DEPTH(2), .TAG_W(4)) u0 (
      .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt), .pipe_flush(pipe_flush),
      .bus(b0.slave), .count_out(cnt0));
   pipe_stage_fifo #(.DATA_W(8), .DEPTH(3), .TAG_W(4)) u1 (
      .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt), .pipe_flush(pipe_flush),
      .bus(b1.slave), .count_out(cnt1));
   pipe_stage_fifo #(.DATA_W(8), .DEPTH(4), .TAG_W(4)) u2 (
      .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt), .pipe_flush(pipe_flush),
      .bus(b2.slave), .count_out(cnt2));
   pipe_stage_fifo #(.DATA_W(8), .DEPTH(1), .TAG_W(2)) u3 (
      .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt), .pipe_flush(pipe_flush),
      .bus(b3.slave), .count_out(cnt3));

   // Uniform views of the four DUTs.
   logic       a_rdy [N];
   logic       a_ov  [N];
   logic [7:0] a_data[N];
   logic [3:0] a_tag [N];
   logic [2:0] a_cnt [N];

   assign a_rdy[0] = b0.in_rdy; assign a_ov[0] = b0.out_valid; assign a_data[0] = b0.out_data;
   assign a_rdy[1] = b1.in_rdy; assign a_ov[1] = b1.out_valid; assign a_data[1] = b1.out_data;
   assign a_rdy[2] = b2.in_rdy; assign a_ov[2] = b2.out_valid; assign a_data[2] = b2.out_data;
   assign a_rdy[3] = b3.in_rdy; assign a_ov[3] = b3.out_valid; assign a_data[3] = b3.out_data;
   assign a_tag[0] = b0.out_tag;
   assign a_tag[1] = b1.out_tag;
   assign a_tag[2] = b2.out_tag;
   assign a_tag[3] = {2'b00, b3.out_tag};
   assign a_cnt[0] = {1'b0, cnt0};
   assign a_cnt[1] = {1'b0, cnt1};
   assign a_cnt[2] = cnt2;
   assign a_cnt[3] = {2'b00, cnt3};

   // Reference model: head-at-index-0 list per DUT plus a free-running tag.
   int unsigned dep   [N];
   int unsigned tw    [N];
   int unsigned m_cnt [N];
   int unsigned m_tag [N];
   logic [7:0]  m_d   [N][4];
   logic [3:0]  m_t   [N][4];

   // Samples from the most recent step.
   logic       s_rdy [N];
   logic       s_ov  [N];
   logic [7:0] s_data[N];
   logic [3:0] s_tag [N];
   logic [2:0] s_cnt [N];
   logic       x_rdy [N];
   logic       x_ov  [N];

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s idx%0d: got %0h expected %0h", nm, idx, act, exp);
      else
         passed++;
   endtask

   // One clock: compare every DUT to the model at negedge, then advance the model.
   task automatic step();
      logic       e_rdy, e_ov;
      logic [7:0] e_d;
      logic [3:0] e_t;
      @(negedge clk_in);
      for (int k = 0; k < N; k++) begin
         e_ov  = (m_cnt[k] != 0);
         e_rdy = !reset_in && !cpu_halt && !pipe_flush && ((m_cnt[k] < dep[k]) || out_rdy);
         e_d   = e_ov ? m_d[k][0] : 8'h00;
         e_t   = e_ov ? m_t[k][0] : 4'h0;
         chk("in_rdy",    k, 32'(a_rdy[k]),  32'(e_rdy));
         chk("out_valid", k, 32'(a_ov[k]),   32'(e_ov));
         chk("out_data",  k, 32'(a_data[k]), 32'(e_d));
         chk("out_tag",   k, 32'(a_tag[k]),  32'(e_t));
         chk("count_out", k, 32'(a_cnt[k]),  m_cnt[k]);
         s_rdy[k] = a_rdy[k]; s_ov[k] = a_ov[k]; s_data[k] = a_data[k];
         s_tag[k] = a_tag[k]; s_cnt[k] = a_cnt[k];
         x_rdy[k] = e_rdy;    x_ov[k] = e_ov;
         if (reset_in) begin
            m_cnt[k] = 0;
            m_tag[k] = 0;
         end else if (pipe_flush) begin
            m_cnt[k] = 0;
         end else begin
            if (e_ov && out_rdy) begin
               for (int i = 0; i < 3; i++) begin
                  m_d[k][i] = m_d[k][i+1];
                  m_t[k][i] = m_t[k][i+1];
               end
               m_cnt[k]--;
            end
            if (in_valid && e_rdy) begin
               m_d[k][m_cnt[k]] = in_data;
               m_t[k][m_cnt[k]] = 4'(m_tag[k]);
               m_cnt[k]++;
               m_tag[k] = (m_tag[k] + 1) % (1 << tw[k]);
            end
         end
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      reset_in = 1'b1; in_valid = 1'b0; out_rdy = 1'b0;
      cpu_halt = 1'b0; pipe_flush = 1'b0; in_data = 8'h00;
      step();
      reset_in = 1'b0;
   endtask

   typedef struct {
      logic       rst, halt, flush, iv;
      logic [7:0] d;
      logic       ordy;
      logic       e_rdy, e_ov;
      logic [7:0] e_d;
      logic [3:0] e_t;
      logic [2:0] e_cnt;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int v;
      int j;
      dep = '{2, 3, 4, 1};
      tw  = '{4, 4, 4, 2};
      for (int k = 0; k < N; k++) begin
         m_cnt[k] = 0;
         m_tag[k] = 0;
      end
      reset_in = 1'b1; cpu_halt = 1'b0; pipe_flush = 1'b0;
      in_valid = 1'b1; out_rdy = 1'b0; in_data = 8'h00;
      @(posedge clk_in);
      #1;

      // Vectors for the DEPTH=2 stage: inputs, then outputs seen before the edge.
      //          rst halt flsh iv  d      ordy rdy ov  out_d  tag cnt
      tbl[0] = '{1'b1,1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,8'h00,4'd0,3'd0};
      tbl[1] = '{1'b1,1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,8'h00,4'd0,3'd0};
      tbl[2] = '{1'b1,1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,8'h00,4'd0,3'd0};
      tbl[3] = '{1'b0,1'b0,1'b0,1'b1,8'hA5,1'b0,1'b1,1'b0,8'h00,4'd0,3'd0};
      tbl[4] = '{1'b0,1'b0,1'b0,1'b1,8'h3C,1'b0,1'b1,1'b1,8'hA5,4'd0,3'd1};
      tbl[5] = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,8'hA5,4'd0,3'd2};
      tbl[6] = '{1'b0,1'b0,1'b1,1'b1,8'h55,1'b0,1'b0,1'b1,8'h3C,4'd1,3'd1};
      tbl[7] = '{1'b0,1'b0,1'b0,1'b1,8'h66,1'b0,1'b1,1'b0,8'h00,4'd0,3'd0};
      tbl[8] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,8'h66,4'd2,3'd1};
      tbl[9] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,8'h00,4'd0,3'd0};
      for (int i = 0; i < 10; i++) begin
         reset_in = tbl[i].rst; cpu_halt = tbl[i].halt; pipe_flush = tbl[i].flush;
         in_valid = tbl[i].iv;  in_data  = tbl[i].d;    out_rdy    = tbl[i].ordy;
         step();
         chk("tbl_in_rdy",    i, 32'(s_rdy[0]),  32'(tbl[i].e_rdy));
         chk("tbl_out_valid", i, 32'(s_ov[0]),   32'(tbl[i].e_ov));
         chk("tbl_out_data",  i, 32'(s_data[0]), 32'(tbl[i].e_d));
         chk("tbl_out_tag",   i, 32'(s_tag[0]),  32'(tbl[i].e_t));
         chk("tbl_count",     i, 32'(s_cnt[0]),  32'(tbl[i].e_cnt));
      end

      // Fill and backpressure, DEPTH=4.
      do_reset();
      v = 1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = 8'(v);
         step();
         if (x_rdy[2]) v++;
      end
      chk("fill_count", 2, 32'(s_cnt[2]), 32'd4);
      chk("fill_held",  2, 32'(s_rdy[2]), 32'd0);
      out_rdy = 1'b1; in_valid = 1'b1; in_data = 8'h05;
      j = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         in_valid = 1'b0;
         if (x_ov[2] && j < 5) begin
            chk("drain_data", j, 32'(s_data[2]), 32'(j + 1));
            chk("drain_tag",  j, 32'(s_tag[2]),  32'(j));
            j++;
         end
      end

      // Full simultaneous push/pop, DEPTH=3.
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(8'h20 + i);
         step();
      end
      out_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 8'(8'h30 + i);
         step();
         chk("full_count", i, 32'(s_cnt[1]),  32'd3);
         chk("full_data",  i, 32'(s_data[1]), (i < 3) ? 32'(8'h20 + i) : 32'(8'h30 + i - 3));
         chk("full_tag",   i, 32'(s_tag[1]),  32'(i));
      end

      // Flush mid-stream, DEPTH=4.
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(8'h40 + i);
         step();
      end
      pipe_flush = 1'b1; in_data = 8'h50;
      step();
      chk("flush_rdy",   2, 32'(s_rdy[2]), 32'd0);
      chk("flush_count", 2, 32'(s_cnt[2]), 32'd3);
      pipe_flush = 1'b0; in_data = 8'h77;
      step();
      chk("post_flush_valid", 2, 32'(s_ov[2]),  32'd0);
      chk("post_flush_count", 2, 32'(s_cnt[2]), 32'd0);
      chk("post_flush_rdy",   2, 32'(s_rdy[2]), 32'd1);
      in_valid = 1'b0;
      step();
      chk("post_flush_data", 2, 32'(s_data[2]), 32'h77);
      chk("post_flush_tag",  2, 32'(s_tag[2]),  32'd3);

      // Halt drains but refuses input, DEPTH=2.
      do_reset();
      in_valid = 1'b1;
      in_data = 8'h81; step();
      in_data = 8'h82; step();
      cpu_halt = 1'b1; out_rdy = 1'b1; in_data = 8'h90;
      step();
      chk("halt_rdy0",  0, 32'(s_rdy[0]),  32'd0);
      chk("halt_data0", 0, 32'(s_data[0]), 32'h81);
      step();
      chk("halt_rdy1",  0, 32'(s_rdy[0]),  32'd0);
      chk("halt_data1", 0, 32'(s_data[0]), 32'h82);
      step();
      chk("halt_rdy2",  0, 32'(s_rdy[0]),  32'd0);
      chk("halt_empty", 0, 32'(s_cnt[0]),  32'd0);
      cpu_halt = 1'b0;
      step();
      chk("resume_rdy", 0, 32'(s_rdy[0]), 32'd1);

      // Tag wrap, DEPTH=1 TAG_W=2.
      do_reset();
      in_valid = 1'b1; out_rdy = 1'b1;
      j = 0;
      for (int i = 0; i < 8; i++) begin
         in_data = 8'(i);
         step();
         if (x_ov[3] && j < 6) begin
            chk("wrap_tag",  j, 32'(s_tag[3]),  32'(j % 4));
            chk("wrap_data", j, 32'(s_data[3]), 32'(j));
            j++;
         end
      end

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset_in   = ($urandom_range(63) == 0);
         pipe_flush = ($urandom_range(15) == 0);
         cpu_halt   = ($urandom_range(3) == 0);
         in_valid   = ($urandom_range(3) != 0);
         out_rdy    = ($urandom_range(1) == 0);
         in_data    = 8'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
